// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// On-chip video source for the pixel stream interface (dout/dv_out/hs_out/
// vs_out). Emits frames of deterministic test patterns with programmable
// geometry and idle gaps between pixels, lines and frames.
//
// Ports
//   clk        : video clock, rising edge
//   rst        : synchronous reset, active-low
//   enable     : run frames continuously; only looked at on frame boundaries
//   pix_count  : pixels per line            (latched at frame start)
//   line_count : lines per frame            (latched at frame start)
//   pattern    : 0 h-ramp, 1 v-ramp, 2 checkerboard, 3 diagonal (latched)
//   pix_gap    : idle cycles after each non-last pixel of a line (latched)
//   line_gap   : idle cycles after the last pixel of a non-last line (latched)
//   frame_gap  : idle cycles after the last pixel of a frame (latched)
//   dout       : pixel data, meaningful while dv_out=1 (0 otherwise)
//   dv_out     : pixel valid
//   hs_out     : first pixel of every line
//   vs_out     : first pixel of line 0
//   frame_done : pulse on the last pixel of a frame
//   busy       : high from frame start through the end of frame_gap
// ---------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [15:0]      pix_count,
  input  logic [15:0]      line_count,
  input  logic [1:0]       pattern,
  input  logic [3:0]       pix_gap,
  input  logic [15:0]      line_gap,
  input  logic [15:0]      frame_gap,
  output logic [WIDTH-1:0] dout,
  output logic             dv_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_PIX, S_PGAP, S_LGAP, S_FGAP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      x_q, x_d, y_q, y_d;
  logic [15:0]      gcnt_q, gcnt_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [15:0]      pc_q, pc_d, lc_q, lc_d;
  logic [1:0]       pat_q, pat_d;
  logic [3:0]       pg_q, pg_d;
  logic [15:0]      lg_q, lg_d, fg_q, fg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d, hs_q, hs_d, vs_q, vs_d, fd_q, fd_d;
  logic             busy_q, busy_d;

  // emit: the next cycle carries pixel (x_d, y_d).
  // try_start: this edge is a frame boundary, so the IDLE decision applies.
  logic emit, try_start, start_ok;

  function automatic logic [WIDTH-1:0] pixel_value(input logic [1:0]  pat,
                                                   input logic [15:0] x,
                                                   input logic [15:0] y,
                                                   input logic [7:0]  fc);
    logic [15:0] sum;
    sum = x + y + {8'd0, fc};
    case (pat)
      2'd0:    return x[WIDTH-1:0];
      2'd1:    return y[WIDTH-1:0];
      2'd2:    return {WIDTH{x[3] ^ y[3]}};
      default: return sum[WIDTH-1:0];
    endcase
  endfunction

  assign start_ok = enable && (pix_count != 16'd0) && (line_count != 16'd0);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    gcnt_d    = gcnt_q;
    fcnt_d    = fcnt_q;
    pc_d      = pc_q;
    lc_d      = lc_q;
    pat_d     = pat_q;
    pg_d      = pg_q;
    lg_d      = lg_q;
    fg_d      = fg_q;
    emit      = 1'b0;
    try_start = 1'b0;

    case (state_q)
      S_IDLE: try_start = 1'b1;

      S_PIX: begin
        if (x_q < pc_q - 16'd1) begin
          x_d = x_q + 16'd1;
          if (pg_q == 4'd0) begin
            emit = 1'b1;
          end else begin
            state_d = S_PGAP;
            gcnt_d  = {12'd0, pg_q};
          end
        end else if (y_q < lc_q - 16'd1) begin
          x_d = 16'd0;
          y_d = y_q + 16'd1;
          if (lg_q == 16'd0) begin
            emit = 1'b1;
          end else begin
            state_d = S_LGAP;
            gcnt_d  = lg_q;
          end
        end else begin
          fcnt_d = fcnt_q + 8'd1;
          if (fg_q == 16'd0) begin
            try_start = 1'b1;
          end else begin
            state_d = S_FGAP;
            gcnt_d  = fg_q;
          end
        end
      end

      S_PGAP, S_LGAP: begin
        if (gcnt_q == 16'd1) emit = 1'b1;
        else                 gcnt_d = gcnt_q - 16'd1;
      end

      S_FGAP: begin
        // The last gap cycle doubles as the IDLE decision so back-to-back
        // frames lose no cycle.
        if (gcnt_q == 16'd1) try_start = 1'b1;
        else                 gcnt_d = gcnt_q - 16'd1;
      end

      default: state_d = S_IDLE;
    endcase

    if (try_start) begin
      if (start_ok) begin
        pc_d  = pix_count;
        lc_d  = line_count;
        pat_d = pattern;
        pg_d  = pix_gap;
        lg_d  = line_gap;
        fg_d  = frame_gap;
        x_d   = 16'd0;
        y_d   = 16'd0;
        emit  = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (emit) state_d = S_PIX;

    // Outputs are computed for the cycle being entered, then registered.
    dv_d   = emit;
    hs_d   = emit && (x_d == 16'd0);
    vs_d   = emit && (x_d == 16'd0) && (y_d == 16'd0);
    fd_d   = emit && (x_d == pc_d - 16'd1) && (y_d == lc_d - 16'd1);
    dout_d = emit ? pixel_value(pat_d, x_d, y_d, fcnt_d) : '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gcnt_q  <= '0;
      fcnt_q  <= '0;
      pc_q    <= '0;
      lc_q    <= '0;
      pat_q   <= '0;
      pg_q    <= '0;
      lg_q    <= '0;
      fg_q    <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gcnt_q  <= gcnt_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      lc_q    <= lc_d;
      pat_q   <= pat_d;
      pg_q    <= pg_d;
      lg_q    <= lg_d;
      fg_q    <= fg_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dv_out     = dv_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
//
// Directed scenarios for video_pattern_gen. A frame-level model expands each
// frame into its expected cycle stream; one compare process checks the DUT
// against that stream every cycle, and literal expectations pin key cycles.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] pix_count, line_count;
  logic [1:0]  pattern;
  logic [3:0]  pix_gap;
  logic [15:0] line_gap, frame_gap;
  logic [7:0]  dout;
  logic        dv_out, hs_out, vs_out, frame_done, busy;

  video_pattern_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pix_count  (pix_count),
    .line_count (line_count),
    .pattern    (pattern),
    .pix_gap    (pix_gap),
    .line_gap   (line_gap),
    .frame_gap  (frame_gap),
    .dout       (dout),
    .dv_out     (dv_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv;
    logic       hs;
    logic       vs;
    logic       fd;
    logic       busy;
    logic [7:0] dout;
  } cyc_t;

  cyc_t       exp_q[$];
  cyc_t       obs[512];
  int         obs_idx = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model_fc = 8'd0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Pattern rules straight from the pattern definitions.
  function automatic logic [7:0] model_pixel(input int pat, input int x,
                                             input int y, input int fc);
    case (pat)
      0:       return 8'(x % 256);
      1:       return 8'(y % 256);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return 8'((x + y + fc) % 256);
    endcase
  endfunction

  task automatic push_idle(input int n, input logic b);
    cyc_t c;
    c = '0;
    c.busy = b;
    for (int i = 0; i < n; i++) exp_q.push_back(c);
  endtask

  // One frame: every pixel followed by the gap that rule assigns to it.
  task automatic push_frame(input int pc, input int lc, input int pat,
                            input int pg, input int lg, input int fg);
    cyc_t c;
    int   n;
    for (int y = 0; y < lc; y++) begin
      for (int x = 0; x < pc; x++) begin
        c.dv   = 1'b1;
        c.hs   = (x == 0);
        c.vs   = (x == 0) && (y == 0);
        c.fd   = (x == pc - 1) && (y == lc - 1);
        c.busy = 1'b1;
        c.dout = model_pixel(pat, x, y, int'(model_fc));
        exp_q.push_back(c);
        n = (x < pc - 1) ? pg : ((y < lc - 1) ? lg : fg);
        push_idle(n, 1'b1);
      end
    end
    model_fc = model_fc + 8'd1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Called just before the edge that starts the first frame.
  task automatic run_frames(input int nframes, input int drop_k, input int tail);
    @(posedge clk);
    obs_idx = 0;
    if (pix_count != 0 && line_count != 0) begin
      for (int f = 0; f < nframes; f++)
        push_frame(int'(pix_count), int'(line_count), int'(pattern),
                   int'(pix_gap), int'(line_gap), int'(frame_gap));
    end
    push_idle(tail, 1'b0);
    repeat (drop_k + 1) @(negedge clk);
    enable = 1'b0;
    drain();
  endtask

  task automatic set_cfg(input int pc, input int lc, input int pat,
                         input int pg, input int lg, input int fg);
    @(negedge clk);
    pix_count  = 16'(pc);
    line_count = 16'(lc);
    pattern    = 2'(pat);
    pix_gap    = 4'(pg);
    line_gap   = 16'(lg);
    frame_gap  = 16'(fg);
    enable     = 1'b1;
  endtask

  function automatic int count_obs(input int which, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       cnt += int'(obs[i].dv);
        1:       cnt += int'(obs[i].vs);
        default: cnt += int'(obs[i].busy);
      endcase
    end
    return cnt;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dv"},   dv_out,     0);
    check({tag, "_hs"},   hs_out,     0);
    check({tag, "_vs"},   vs_out,     0);
    check({tag, "_fd"},   frame_done, 0);
    check({tag, "_busy"}, busy,       0);
    check({tag, "_dout"}, dout,       0);
  endtask

  always @(negedge clk) begin : compare
    cyc_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {dv_out, hs_out, vs_out, frame_done, busy, dout};
      check($sformatf("stream[%0d]", obs_idx), {19'd0, a}, {19'd0, e});
      if (obs_idx < 512) obs[obs_idx] = a;
      obs_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int diag_exp[8] = '{0, 1, 1, 2, 1, 2, 2, 3};
  int ramp_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b0; enable = 1'b0;
    pix_count = '0; line_count = '0; pattern = '0;
    pix_gap = '0; line_gap = '0; frame_gap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Diagonal 2x2, two frames, frame_cnt starts at 0.
    set_cfg(2, 2, 3, 0, 0, 1);
    run_frames(2, 5, 4);
    for (int i = 0; i < 8; i++)
      check($sformatf("diag_px%0d", i), obs[(i < 4) ? i : i + 1].dout, diag_exp[i]);

    // 4x2 h-ramp, frame_gap=2, two frames back to back.
    set_cfg(4, 2, 0, 0, 0, 2);
    run_frames(2, 12, 5);
    for (int i = 0; i < 8; i++)
      check($sformatf("ramp_px%0d", i), obs[i].dout, ramp_exp[i]);
    check("ramp_hs0", obs[0].hs, 1);
    check("ramp_hs1", obs[1].hs, 0);
    check("ramp_hs4", obs[4].hs, 1);
    check("ramp_vs0", obs[0].vs, 1);
    check("ramp_vs4", obs[4].vs, 0);
    check("ramp_fd7", obs[7].fd, 1);
    check("ramp_vs10", obs[10].vs, 1);

    // 4x1, pix_gap=1.
    set_cfg(4, 1, 0, 1, 0, 0);
    run_frames(1, 0, 4);
    for (int i = 0; i < 8; i++)
      check($sformatf("pgap_dv%0d", i), obs[i].dv, (i % 2 == 0 && i < 7) ? 1 : 0);
    check("pgap_fd6", obs[6].fd, 1);

    // 16x16 checkerboard.
    set_cfg(16, 16, 2, 0, 0, 0);
    run_frames(1, 0, 4);
    check("chk_0_0", obs[0].dout, 8'h00);
    check("chk_8_0", obs[8].dout, 8'hFF);
    check("chk_0_8", obs[128].dout, 8'hFF);
    check("chk_8_8", obs[136].dout, 8'h00);
    check("chk_dv_count", count_obs(0, 260), 256);
    check("chk_vs_count", count_obs(1, 260), 1);

    // 8x8 with all gaps, enable dropped on pixel 3 (cycle 6 with pix_gap=1).
    set_cfg(8, 8, 0, 1, 2, 3);
    run_frames(1, 6, 4);
    check("drop_dv_count", count_obs(0, 141), 64);
    check("drop_vs_count", count_obs(1, 141), 1);
    check("drop_fd133", obs[133].fd, 1);
    check("drop_busy136", obs[136].busy, 1);
    check("drop_busy137", obs[137].busy, 0);

    // pix_count=0 never starts a frame.
    set_cfg(0, 8, 0, 0, 0, 0);
    run_frames(0, 99, 100);
    check("zero_dv_count", count_obs(0, 100), 0);
    check("zero_busy_count", count_obs(2, 100), 0);

    // Reset in the middle of a line.
    set_cfg(8, 4, 3, 0, 0, 0);
    @(posedge clk);
    repeat (4) @(negedge clk);
    check("prerst_dv", dv_out, 1);
    check("prerst_dout", dout, 8'(3 + int'(model_fc)));
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b1;
    model_fc = 8'd0;
    run_frames(1, 0, 4);
    check("postrst_vs0", obs[0].vs, 1);
    check("postrst_dout0", obs[0].dout, 0);
    check("postrst_dout9", obs[9].dout, 2);
    check("postrst_fd31", obs[31].fd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
